// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS tuning word and enable.
// Define SWEEP_PHASE_RESYNC_EN to drop dds_en for the reload cycle of every loop-mode wrap.
module dds_sweep_ctrl #(
    parameter int FREQ_W  = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               dds_en,
    output logic               busy,
    output logic               step_tick,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [FREQ_W-1:0]  start_cfg_q, start_cfg_d;
    logic [FREQ_W-1:0]  stop_cfg_q, stop_cfg_d;
    logic [FREQ_W-1:0]  step_cfg_q, step_cfg_d;
    logic [FREQ_W-1:0]  target_q, target_d;
    logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               up_q, up_d;
    logic               dds_en_q, dds_en_d;
    logic               busy_q, busy_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;

    logic [FREQ_W-1:0]  rev_target;
    logic [FREQ_W-1:0]  nxt_fwd;
    logic [FREQ_W-1:0]  nxt_rev;

    // Carry/borrow from the extra bit forces a clamp, so the endpoint is always hit exactly.
    function automatic logic [FREQ_W-1:0] step_toward(
        input logic [FREQ_W-1:0] cur,
        input logic [FREQ_W-1:0] tgt,
        input logic [FREQ_W-1:0] stp,
        input logic              up
    );
        logic [FREQ_W:0]   wide;
        logic [FREQ_W-1:0] res;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, stp};
            res  = (wide[FREQ_W] || (wide[FREQ_W-1:0] > tgt)) ? tgt : wide[FREQ_W-1:0];
        end else begin
            wide = {1'b0, cur} - {1'b0, stp};
            res  = (wide[FREQ_W] || (wide[FREQ_W-1:0] < tgt)) ? tgt : wide[FREQ_W-1:0];
        end
        return res;
    endfunction

    assign rev_target = (target_q == stop_cfg_q) ? start_cfg_q : stop_cfg_q;
    assign nxt_fwd    = step_toward(freq_q, target_q, step_cfg_q, up_q);
    assign nxt_rev    = step_toward(freq_q, rev_target, step_cfg_q, !up_q);

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        start_cfg_d = start_cfg_q;
        stop_cfg_d  = stop_cfg_q;
        step_cfg_d  = step_cfg_q;
        target_d    = target_q;
        dwell_cfg_d = dwell_cfg_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        up_d        = up_q;
        dds_en_d    = dds_en_q;
        busy_d      = busy_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;

        if (stop) begin
            if (state_q != ST_IDLE) begin
                state_d  = ST_IDLE;
                dds_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        end else if (start) begin
            state_d     = ST_RUN;
            start_cfg_d = f_start;
            stop_cfg_d  = f_stop;
            step_cfg_d  = f_step;
            mode_d      = mode;
            target_d    = f_stop;
            up_d        = (f_stop >= f_start);
            dwell_cfg_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            cnt_d       = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            freq_d      = f_start;
            dds_en_d    = 1'b1;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    dds_en_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        cnt_d = dwell_cfg_q;
                        if (freq_q == target_q) begin
                            case (mode_q)
                                2'd1: begin
                                    freq_d = start_cfg_q;
                                    tick_d = 1'b1;
`ifdef SWEEP_PHASE_RESYNC_EN
                                    dds_en_d = 1'b0;
`else
                                    dds_en_d = 1'b1;
`endif
                                end
                                2'd2: begin
                                    // Reversal takes the first step of the new leg immediately.
                                    target_d = rev_target;
                                    up_d     = !up_q;
                                    freq_d   = nxt_rev;
                                    tick_d   = 1'b1;
                                end
                                default: begin
                                    state_d = ST_HOLD;
                                    done_d  = 1'b1;
                                end
                            endcase
                        end else begin
                            freq_d = nxt_fwd;
                            tick_d = (nxt_fwd != freq_q);
                        end
                    end
                end
                ST_HOLD: begin
                    dds_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
                default: begin
                    dds_en_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            freq_q      <= '0;
            start_cfg_q <= '0;
            stop_cfg_q  <= '0;
            step_cfg_q  <= '0;
            target_q    <= '0;
            dwell_cfg_q <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            up_q        <= 1'b0;
            dds_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            start_cfg_q <= start_cfg_d;
            stop_cfg_q  <= stop_cfg_d;
            step_cfg_q  <= step_cfg_d;
            target_q    <= target_d;
            dwell_cfg_q <= dwell_cfg_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            up_q        <= up_d;
            dds_en_q    <= dds_en_d;
            busy_q      <= busy_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
    end

    assign freq_out  = freq_q;
    assign dds_en    = dds_en_q;
    assign busy      = busy_q;
    assign step_tick = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand-written corners,
// and random sweeps checked against a value-sequence model of the sweep.
module tb_dds_sweep_ctrl;

`ifdef SWEEP_PHASE_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] freq_out;
    logic        dds_en;
    logic        busy;
    logic        step_tick;
    logic        done;

    int n_compared;
    int n_mismatched;

    typedef struct packed {
        logic [1:0]        mode;
        logic [31:0]       fs;
        logic [31:0]       fe;
        logic [31:0]       st;
        logic [15:0]       dw;
        logic [3:0]        nvals;
        logic [6:0][31:0]  vals;
    } vec_t;

    vec_t vec_tab[$];

    logic [31:0] exp_f[$];
    logic        exp_t[$];
    logic        exp_d[$];
    logic        exp_e[$];

    dds_sweep_ctrl #(.FREQ_W(32), .DWELL_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .freq_out  (freq_out),
        .dds_en    (dds_en),
        .busy      (busy),
        .step_tick (step_tick),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string name, input logic [31:0] ef, input logic et,
                               input logic ed, input logic ee, input logic eb);
        checkOutput({name, ".freq_out"}, freq_out, ef);
        checkOutput({name, ".step_tick"}, {31'd0, step_tick}, {31'd0, et});
        checkOutput({name, ".done"}, {31'd0, done}, {31'd0, ed});
        checkOutput({name, ".dds_en"}, {31'd0, dds_en}, {31'd0, ee});
        checkOutput({name, ".busy"}, {31'd0, busy}, {31'd0, eb});
    endtask

    // Start pulse with the given config, then scramble the config inputs to prove they were latched.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                                 input logic [31:0] st, input logic [15:0] dw);
        mode    = m;
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
        next_cycle();
        start   = 1'b0;
        mode    = 2'($urandom_range(0, 3));
        f_start = $urandom;
        f_stop  = $urandom;
        f_step  = $urandom;
        dwell   = 16'($urandom_range(0, 9));
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                           input logic [31:0] st, input logic [15:0] dw, input int n,
                           input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input logic [31:0] v4, input logic [31:0] v5,
                           input logic [31:0] v6);
        vec_t v;
        v.mode    = m;
        v.fs      = fs;
        v.fe      = fe;
        v.st      = st;
        v.dw      = dw;
        v.nvals   = 4'(n);
        v.vals[0] = v0;
        v.vals[1] = v1;
        v.vals[2] = v2;
        v.vals[3] = v3;
        v.vals[4] = v4;
        v.vals[5] = v5;
        v.vals[6] = v6;
        vec_tab.push_back(v);
    endtask

    function automatic longint toward(input longint cur, input longint tgt, input longint st);
        longint n;
        if (tgt >= cur) begin
            n = cur + st;
            if (n > tgt) n = tgt;
        end else begin
            n = cur - st;
            if (n < tgt) n = tgt;
        end
        return n;
    endfunction

    task automatic push_entry(input longint val, input logic tick, input logic en, input int d);
        for (int c = 0; c < d; c++) begin
            exp_f.push_back(val[31:0]);
            exp_t.push_back((c == 0) ? tick : 1'b0);
            exp_d.push_back(1'b0);
            exp_e.push_back((c == 0) ? en : 1'b1);
        end
    endtask

    // Expected per-cycle trace: a list of held values, each lasting max(dwell,1) cycles.
    task automatic build_model(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input logic [15:0] dw, input int n);
        longint cur, tgt, lfs, lfe, lst, nxt;
        bit     returning;
        int     d;
        exp_f.delete();
        exp_t.delete();
        exp_d.delete();
        exp_e.delete();
        lfs = {32'd0, fs};
        lfe = {32'd0, fe};
        lst = {32'd0, st};
        d   = (dw == 16'd0) ? 1 : int'(dw);
        cur = lfs;
        tgt = lfe;
        returning = 1'b0;
        push_entry(cur, 1'b0, 1'b1, d);
        while (exp_f.size() < n) begin
            if (cur == tgt) begin
                if (m == 2'd1) begin
                    cur = lfs;
                    push_entry(cur, 1'b1, !RESYNC, d);
                end else if (m == 2'd2) begin
                    returning = !returning;
                    tgt = returning ? lfs : lfe;
                    cur = toward(cur, tgt, lst);
                    push_entry(cur, 1'b1, 1'b1, d);
                end else begin
                    exp_f.push_back(fe);
                    exp_t.push_back(1'b0);
                    exp_d.push_back(1'b1);
                    exp_e.push_back(1'b1);
                    while (exp_f.size() < n) begin
                        exp_f.push_back(fe);
                        exp_t.push_back(1'b0);
                        exp_d.push_back(1'b0);
                        exp_e.push_back(1'b1);
                    end
                end
            end else begin
                nxt = toward(cur, tgt, lst);
                push_entry(nxt, nxt != cur, 1'b1, d);
                cur = nxt;
            end
        end
    endtask

    initial begin
        int          d;
        int          total;
        logic [31:0] held;
        logic [31:0] v;
        logic        en_exp;
        logic [1:0]  rm;
        logic [31:0] base, rfs, rfe, rst_v;
        logic [15:0] rdw;

        n_compared   = 0;
        n_mismatched = 0;

        add_vec(2'd0, 32'd100, 32'd130, 32'd10, 16'd4, 4, 32'd100, 32'd110, 32'd120, 32'd130, 0, 0, 0);
        add_vec(2'd0, 32'd0, 32'd25, 32'd10, 16'd1, 4, 32'd0, 32'd10, 32'd20, 32'd25, 0, 0, 0);
        add_vec(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2'd1, 32'd100, 32'd120, 32'd10, 16'd2, 7, 32'd100, 32'd110, 32'd120, 32'd100, 32'd110, 32'd120, 32'd100);
        add_vec(2'd2, 32'd50, 32'd20, 32'd15, 16'd3, 7, 32'd50, 32'd35, 32'd20, 32'd35, 32'd50, 32'd35, 32'd20);
        add_vec(2'd0, 32'd5, 32'd8, 32'd2, 16'd0, 3, 32'd5, 32'd7, 32'd8, 0, 0, 0, 0);
        add_vec(2'd1, 32'd7, 32'd7, 32'd3, 16'd2, 3, 32'd7, 32'd7, 32'd7, 0, 0, 0, 0);
        add_vec(2'd3, 32'd10, 32'd12, 32'd1, 16'd1, 3, 32'd10, 32'd11, 32'd12, 0, 0, 0, 0);

        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'd0;
        f_start = 32'd0;
        f_stop  = 32'd0;
        f_step  = 32'd0;
        dwell   = 16'd0;
        next_cycle();
        next_cycle();
        check_cycle("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        check_cycle("post_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vec_tab[vi]) begin
            d     = (vec_tab[vi].dw == 16'd0) ? 1 : int'(vec_tab[vi].dw);
            total = int'(vec_tab[vi].nvals) * d;
            applyStimulus(vec_tab[vi].mode, vec_tab[vi].fs, vec_tab[vi].fe, vec_tab[vi].st, vec_tab[vi].dw);
            for (int i = 0; i < total; i++) begin
                v      = vec_tab[vi].vals[i / d];
                en_exp = !(RESYNC && vec_tab[vi].mode == 2'd1 && (i / d) > 0 && (i % d) == 0
                           && v == vec_tab[vi].fs);
                check_cycle($sformatf("vec%0d.c%0d", vi, i), v, (i / d) > 0 && (i % d) == 0,
                            1'b0, en_exp, 1'b1);
                if (i != total - 1) next_cycle();
            end
            held = vec_tab[vi].vals[vec_tab[vi].nvals - 1];
            if (vec_tab[vi].mode == 2'd0 || vec_tab[vi].mode == 2'd3) begin
                next_cycle();
                check_cycle($sformatf("vec%0d.hold_done", vi), vec_tab[vi].fe, 1'b0, 1'b1, 1'b1, 1'b1);
                next_cycle();
                check_cycle($sformatf("vec%0d.hold", vi), vec_tab[vi].fe, 1'b0, 1'b0, 1'b1, 1'b1);
                next_cycle();
                check_cycle($sformatf("vec%0d.hold2", vi), vec_tab[vi].fe, 1'b0, 1'b0, 1'b1, 1'b1);
            end
            stop = 1'b1;
            next_cycle();
            stop = 1'b0;
            check_cycle($sformatf("vec%0d.stopped", vi), held, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // stop and start together mid-run: stop wins, frequency held
        applyStimulus(2'd1, 32'd100, 32'd200, 32'd10, 16'd3);
        repeat (4) next_cycle();
        check_cycle("ss.pre", 32'd110, 1'b0, 1'b0, 1'b1, 1'b1);
        mode    = 2'd0;
        f_start = 32'd999;
        f_stop  = 32'd1999;
        f_step  = 32'd1;
        dwell   = 16'd1;
        start   = 1'b1;
        stop    = 1'b1;
        next_cycle();
        start = 1'b0;
        stop  = 1'b0;
        check_cycle("ss.idle", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_cycle("ss.idle2", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check_cycle("stop_in_idle", 32'd110, 1'b0, 1'b0, 1'b0, 1'b0);

        // start during HOLD restarts with the new config
        applyStimulus(2'd0, 32'd10, 32'd12, 32'd1, 16'd1);
        repeat (3) next_cycle();
        check_cycle("hold.done", 32'd12, 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        applyStimulus(2'd0, 32'd500, 32'd600, 32'd50, 16'd2);
        check_cycle("hold.restart", 32'd500, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        next_cycle();
        check_cycle("hold.restart_step", 32'd550, 1'b1, 1'b0, 1'b1, 1'b1);

        // reset mid-run clears everything next cycle
        rst_n = 1'b0;
        next_cycle();
        check_cycle("rst_mid", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        check_cycle("rst_after", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            rm   = 2'($urandom_range(0, 3));
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'd0;
            rfs  = base + $urandom_range(0, 200);
            rfe  = ($urandom_range(0, 7) == 0) ? rfs : base + $urandom_range(0, 200);
            case ($urandom_range(0, 7))
                0:       rst_v = 32'd0;
                1:       rst_v = 32'h200;
                default: rst_v = $urandom_range(1, 60);
            endcase
            rdw = 16'($urandom_range(0, 4));
            build_model(rm, rfs, rfe, rst_v, rdw, 40);
            applyStimulus(rm, rfs, rfe, rst_v, rdw);
            for (int i = 0; i < 40; i++) begin
                check_cycle($sformatf("rnd%0d.c%0d", r, i), exp_f[i], exp_t[i], exp_d[i], exp_e[i], 1'b1);
                if (i != 39) next_cycle();
            end
            stop = 1'b1;
            next_cycle();
            stop = 1'b0;
            check_cycle($sformatf("rnd%0d.stopped", r), exp_f[39], 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Linear frequency-sweep controller sitting directly upstream of the DDS core.
- Drives the DDS FreqCntrl word and its en input.
- Steps the tuning word from a start to a stop value at a programmable dwell per step.
- Supports single-shot, looping and ping-pong modes.
- All control inputs come from AXI registers; start/stop arrive as single-cycle pulses.

Parameters:
FREQ_W, 32, width of tuning words (f_start, f_stop, f_step, freq_out)
DWELL_W, 16, width of dwell counter/config

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse; latch config and (re)start sweep
stop  in  1  pulse; abort sweep, return to IDLE
mode  in  2  0=single, 1=loop, 2=ping-pong, 3=reserved (treated as single)
f_start  in  FREQ_W  first tuning word
f_stop  in  FREQ_W  final tuning word
f_step  in  FREQ_W  unsigned step magnitude
dwell  in  DWELL_W  clock cycles per step; 0 treated as 1
freq_out  out  FREQ_W  tuning word to DDS FreqCntrl
dds_en  out  1  to DDS en; high while sweeping/holding
busy  out  1  high in RUN or HOLD
step_tick  out  1  1-cycle pulse each time freq_out changes value by a step, reload or reversal
done  out  1  1-cycle pulse when single sweep reaches f_stop

Behaviour:
- Reset: freq_out=0, dds_en=0, busy=0, step_tick=0, done=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: dds_en=0, freq_out holds its last value.
  - RUN: stepping.
  - HOLD: single mode finished; freq_out=f_stop, dds_en=1.
- Start:
  - Start sampled high in cycle N latches f_start, f_stop, f_step, dwell and mode.
  - Cycle N+1: freq_out=f_start, dds_en=1, busy=1, state=RUN.
  - Direction is latched as up if f_stop>=f_start, else down.
  - Later changes to the config inputs have no effect until the next start.
- Start in RUN or HOLD restarts immediately with the new config.
- Stop: next cycle state=IDLE, dds_en=0, busy=0; freq_out is held.
- Stop and start in the same cycle: stop wins.
- Stop in IDLE: no effect.
- Dwell: counter loads dwell-1 on entry to each step value and decrements each cycle; expiry at 0 means freq_out is held exactly max(dwell,1) cycles.
- Step computation on expiry:
  - Computed in FREQ_W+1 bits.
  - Up: next = freq_out+f_step; if next > end target or the carry out is set, next = end target.
  - Down: next = freq_out-f_step; if next < end target or a borrow occurs, next = end target.
  - Clamp guarantees the end value is hit exactly.
- End reached: expiry while freq_out == end target (end target = f_stop for up-leg, f_start for ping-pong down-leg).
  - single: state=HOLD, done=1 for one cycle, freq_out stays f_stop.
  - loop: freq_out=f_start next cycle, step_tick=1.
  - ping-pong: direction reverses and the end target swaps. The first step of the new leg happens at this same expiry, so the endpoint value is held exactly one dwell.
- f_start==f_stop: end is reached at the first expiry.
  - single: HOLD after one dwell.
  - loop/ping-pong: value constant; step_tick still pulses per dwell.
- f_step==0 with f_start!=f_stop: freq_out frozen at f_start; end never reached; runs until stop/start. step_tick does not pulse.
- step_tick: asserted in the same cycle freq_out takes a new value (not on initial load at start).
- Reset mid-sweep: all outputs return to reset values the next cycle.

Optional Feature:
SWEEP_PHASE_RESYNC_EN
- Defined: in loop mode, on every wrap reload to f_start, dds_en is driven 0 for exactly the reload cycle, then 1 again. This zeroes the DDS accumulator so each sweep starts at phase 0.
- Not defined: dds_en stays 1 continuously through wraps.
- Other modes are unaffected either way.

Test Plan:
- Single up: f_start=100, f_stop=130, f_step=10, dwell=4, mode=0 -> freq_out 100,110,120,130 each for 4 cycles; done pulses once; HOLD with dds_en=1 until stop.
- Clamp: f_start=0, f_stop=25, f_step=10, dwell=1 -> freq_out 0,10,20,25; done; no overshoot.
- Overflow clamp: f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20 -> second value 0xFFFFFFFF, not a wrap.
- Loop: 100->120 step 10, dwell=2, mode=1 -> 100,100,110,110,120,120,100,... Two full periods checked. With SWEEP_PHASE_RESYNC_EN, dds_en=0 exactly one cycle at each reload.
- Ping-pong down-start: f_start=50, f_stop=20, f_step=15, dwell=3, mode=2 -> 50,35,20,35,50,35,... each for 3 cycles; step_tick on every change.
- Control corners:
  - stop+start same cycle mid-RUN -> IDLE, dds_en=0.
  - start during HOLD -> restart at new f_start next cycle.
  - dwell=0 behaves as dwell=1.
  - rst_n low mid-RUN -> all outputs 0 next cycle.
